// File: rtl/cpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sram_arbiter
//  Purpose  : Shares one sram-like slave port between the CPU instruction and
//             data sram-like masters. Data has priority, with an anti-starvation
//             limit that forces an instruction grant. A request that is not
//             accepted immediately locks the grant until the slave accepts it
//             or the master abandons it. The grant order of accepted requests
//             is recorded in an ID FIFO, and in-order data_ok returns are
//             steered back to the owning master.
//  Ports    : clk, resetn (async, active low)
//             inst_sram_* / data_sram_* : master-side sram-like ports
//             sram_*                    : shared slave-side sram-like port
//             outstanding               : in-flight request count (debug)
//  Revision : 1.0  initial release
// ============================================================================
module cpu_sram_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 2
) (
    input  logic                       clk,
    input  logic                       resetn,

    input  logic                       inst_sram_req,
    input  logic                       inst_sram_wr,
    input  logic [1:0]                 inst_sram_size,
    input  logic [3:0]                 inst_sram_wstrb,
    input  logic [31:0]                inst_sram_addr,
    input  logic [31:0]                inst_sram_wdata,
    output logic                       inst_sram_addr_ok,
    output logic                       inst_sram_data_ok,
    output logic [31:0]                inst_sram_rdata,

    input  logic                       data_sram_req,
    input  logic                       data_sram_wr,
    input  logic [1:0]                 data_sram_size,
    input  logic [3:0]                 data_sram_wstrb,
    input  logic [31:0]                data_sram_addr,
    input  logic [31:0]                data_sram_wdata,
    output logic                       data_sram_addr_ok,
    output logic                       data_sram_data_ok,
    output logic [31:0]                data_sram_rdata,

    output logic                       sram_req,
    output logic                       sram_wr,
    output logic [1:0]                 sram_size,
    output logic [3:0]                 sram_wstrb,
    output logic [31:0]                sram_addr,
    output logic [31:0]                sram_wdata,
    input  logic                       sram_addr_ok,
    input  logic                       sram_data_ok,
    input  logic [31:0]                sram_rdata,

    output logic [$clog2(DEPTH):0]     outstanding
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    localparam logic [0:0]    c_IDLE       = 1'b0;
    localparam logic [0:0]    c_HOLD       = 1'b1;
    localparam logic          c_INST       = 1'b0;
    localparam logic          c_DATA       = 1'b1;
    localparam logic [CW-1:0] c_DEPTH      = CW'(DEPTH);
    localparam logic [SW-1:0] c_STARVE_LIM = SW'(STARVE_LIM);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic             r_lock_id;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [DEPTH-1:0] r_fifo;
    logic [SW-1:0]    r_starve;

    logic [0:0]       w_state_nxt;
    logic             w_lock_id_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [SW-1:0]    w_starve_nxt;

    logic             w_grant;
    logic             w_granted_req;
    logic             w_can_issue;
    logic             w_req;
    logic             w_push;
    logic             w_pop;
    logic             w_head;

    // ------------------------------------------------------------------
    // Grant selection: the lock overrides priority; otherwise data wins
    // a contested cycle unless inst has been passed over STARVE_LIM times.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = c_DATA;
        if (r_state == c_HOLD) begin
            w_grant = r_lock_id;
        end else if (inst_sram_req && !data_sram_req) begin
            w_grant = c_INST;
        end else if (inst_sram_req && data_sram_req && (r_starve == c_STARVE_LIM)) begin
            w_grant = c_INST;
        end else begin
            w_grant = c_DATA;
        end
    end

    assign w_granted_req = (w_grant == c_DATA) ? data_sram_req : inst_sram_req;
    assign w_can_issue   = (r_cnt < c_DEPTH);
    assign w_req         = w_can_issue & w_granted_req;
    assign w_push        = w_req & sram_addr_ok;
    // Pop is qualified on the old count so a spurious data_ok is dropped.
    assign w_pop         = sram_data_ok & (r_cnt != '0);
    assign w_head        = r_fifo[r_rd_ptr];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_IDLE;
            r_lock_id <= c_INST;
            r_cnt     <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_fifo    <= '0;
            r_starve  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_id_nxt;
            r_cnt     <= w_cnt_nxt;
            r_starve  <= w_starve_nxt;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_grant;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_id_nxt = r_lock_id;
        case (r_state)
            c_IDLE: begin
                if (w_req && !sram_addr_ok) begin
                    w_state_nxt   = c_HOLD;
                    w_lock_id_nxt = w_grant;
                end
            end
            c_HOLD: begin
                // Release on acceptance or when the locked master abandons.
                if (w_push || !w_granted_req) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (!inst_sram_req) begin
            w_starve_nxt = '0;
        end else if (w_push && (w_grant == c_INST)) begin
            w_starve_nxt = '0;
        end else if (w_push && (r_starve != c_STARVE_LIM)) begin
            w_starve_nxt = r_starve + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: combinational request and return paths, all forced low
    // while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        sram_req          = 1'b0;
        sram_wr           = 1'b0;
        sram_size         = 2'b0;
        sram_wstrb        = 4'b0;
        sram_addr         = 32'b0;
        sram_wdata        = 32'b0;
        inst_sram_addr_ok = 1'b0;
        data_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'b0;
        data_sram_rdata   = 32'b0;
        outstanding       = '0;
        if (resetn) begin
            sram_req          = w_req;
            sram_wr           = (w_grant == c_DATA) ? data_sram_wr    : inst_sram_wr;
            sram_size         = (w_grant == c_DATA) ? data_sram_size  : inst_sram_size;
            sram_wstrb        = (w_grant == c_DATA) ? data_sram_wstrb : inst_sram_wstrb;
            sram_addr         = (w_grant == c_DATA) ? data_sram_addr  : inst_sram_addr;
            sram_wdata        = (w_grant == c_DATA) ? data_sram_wdata : inst_sram_wdata;
            inst_sram_addr_ok = w_push & (w_grant == c_INST);
            data_sram_addr_ok = w_push & (w_grant == c_DATA);
            inst_sram_data_ok = w_pop & (w_head == c_INST);
            data_sram_data_ok = w_pop & (w_head == c_DATA);
            inst_sram_rdata   = sram_rdata;
            data_sram_rdata   = sram_rdata;
            outstanding       = r_cnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_sram_arbiter
//  Purpose  : Self-checking bench for cpu_sram_arbiter. A queue-based model
//             predicts every output each cycle; directed sequences pin the
//             model with literal expectations, then random traffic follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_sram_arbiter;

    localparam int DEPTH = 4;
    localparam int LIM   = 2;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;
    logic [$clog2(DEPTH):0] outstanding;

    cpu_sram_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
        .sram_rdata(sram_rdata), .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: accepted-id queue, lock flag, starvation tally.
    // Ids: 0 = inst, 1 = data.
    // ------------------------------------------------------------------
    bit m_q[$];
    bit m_hold;
    bit m_lock;
    int m_starve;

    always @(negedge clk) begin
        bit g, greq, ereq, acc, pop, head;
        int sz;
        if (!resetn) begin
            chk("rst_sram_req", 32'(sram_req), 0);
            chk("rst_inst_addr_ok", 32'(inst_sram_addr_ok), 0);
            chk("rst_data_addr_ok", 32'(data_sram_addr_ok), 0);
            chk("rst_inst_data_ok", 32'(inst_sram_data_ok), 0);
            chk("rst_data_data_ok", 32'(data_sram_data_ok), 0);
            chk("rst_outstanding", 32'(outstanding), 0);
            chk("rst_sram_addr", sram_addr, 0);
            chk("rst_rdata", inst_sram_rdata | data_sram_rdata, 0);
            m_q.delete();
            m_hold   = 0;
            m_lock   = 0;
            m_starve = 0;
        end else begin
            sz = m_q.size();
            if (m_hold)                               g = m_lock;
            else if (inst_sram_req && !data_sram_req) g = 0;
            else if (inst_sram_req && data_sram_req)  g = (m_starve == LIM) ? 1'b0 : 1'b1;
            else                                      g = 1;
            greq = g ? data_sram_req : inst_sram_req;
            ereq = (sz < DEPTH) && greq;
            acc  = ereq && sram_addr_ok;
            pop  = sram_data_ok && (sz != 0);
            head = (sz != 0) ? m_q[0] : 1'b0;

            chk("sram_req", 32'(sram_req), 32'(ereq));
            chk("outstanding", 32'(outstanding), 32'(sz));
            chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(acc && !g));
            chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(acc && g));
            chk("inst_data_ok", 32'(inst_sram_data_ok), 32'(pop && !head));
            chk("data_data_ok", 32'(data_sram_data_ok), 32'(pop && head));
            chk("inst_rdata", inst_sram_rdata, sram_rdata);
            chk("data_rdata", data_sram_rdata, sram_rdata);
            if (ereq) begin
                chk("sram_addr", sram_addr, g ? data_sram_addr : inst_sram_addr);
                chk("sram_wdata", sram_wdata, g ? data_sram_wdata : inst_sram_wdata);
                chk("sram_ctl", 32'({sram_wr, sram_size, sram_wstrb}),
                    g ? 32'({data_sram_wr, data_sram_size, data_sram_wstrb})
                      : 32'({inst_sram_wr, inst_sram_size, inst_sram_wstrb}));
            end

            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(g);
            if (!m_hold) begin
                if (ereq && !sram_addr_ok) begin
                    m_hold = 1;
                    m_lock = g;
                end
            end else if (acc || !greq) begin
                m_hold = 0;
            end
            if (!inst_sram_req)  m_starve = 0;
            else if (acc && !g)  m_starve = 0;
            else if (acc && g)   m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'hf;
        inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'hf;
        data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = 32'h0;
    endtask

    task automatic drain(input int n);
        sram_data_ok = 1;
        for (int i = 0; i < n; i++) step();
        sram_data_ok = 0;
        @(negedge clk);
        chk("drain_outstanding", 32'(outstanding), 0);
    endtask

    bit exp5 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        clear_inputs();
        resetn = 0;
        // Reset state with every request input active.
        inst_sram_req = 1; data_sram_req = 1; sram_addr_ok = 1; sram_data_ok = 1;
        @(negedge clk);
        chk("reset_sram_req", 32'(sram_req), 0);
        chk("reset_outstanding", 32'(outstanding), 0);
        chk("reset_data_addr_ok", 32'(data_sram_addr_ok), 0);
        step();
        clear_inputs();
        resetn = 1;

        // 1: single inst read, data_ok two cycles after acceptance.
        step();
        inst_sram_req = 1; inst_sram_addr = 32'hbfc00000; sram_addr_ok = 1;
        @(negedge clk);
        chk("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 1);
        chk("t1_sram_addr", sram_addr, 32'hbfc00000);
        step();
        inst_sram_req = 0; sram_addr_ok = 0;
        @(negedge clk);
        chk("t1_outstanding", 32'(outstanding), 1);
        step();
        sram_data_ok = 1; sram_rdata = 32'h3c1d1234;
        @(negedge clk);
        chk("t1_inst_data_ok", 32'(inst_sram_data_ok), 1);
        chk("t1_inst_rdata", inst_sram_rdata, 32'h3c1d1234);
        chk("t1_data_data_ok", 32'(data_sram_data_ok), 0);
        step();
        sram_data_ok = 0;
        @(negedge clk);
        chk("t1_outstanding_end", 32'(outstanding), 0);

        // 2: simultaneous requests, data first both ways.
        step();
        inst_sram_req = 1; data_sram_req = 1; sram_addr_ok = 1;
        @(negedge clk);
        chk("t2_data_first", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'b01);
        step();
        data_sram_req = 0;
        @(negedge clk);
        chk("t2_inst_second", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'b10);
        step();
        inst_sram_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
        @(negedge clk);
        chk("t2_ret_data", 32'({inst_sram_data_ok, data_sram_data_ok}), 32'b01);
        step();
        @(negedge clk);
        chk("t2_ret_inst", 32'({inst_sram_data_ok, data_sram_data_ok}), 32'b10);
        step();
        sram_data_ok = 0;

        // 3: inst locked while the slave stalls.
        step();
        inst_sram_req = 1; inst_sram_addr = 32'h10000000; data_sram_addr = 32'h20000000;
        @(negedge clk);
        chk("t3_addr_c0", sram_addr, 32'h10000000);
        step();
        data_sram_req = 1;
        @(negedge clk);
        chk("t3_addr_c1", sram_addr, 32'h10000000);
        chk("t3_data_addr_ok_c1", 32'(data_sram_addr_ok), 0);
        step();
        @(negedge clk);
        chk("t3_addr_c2", sram_addr, 32'h10000000);
        step();
        sram_addr_ok = 1;
        @(negedge clk);
        chk("t3_accept_inst", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'b10);
        step();
        inst_sram_req = 0;
        @(negedge clk);
        chk("t3_accept_data", 32'(data_sram_addr_ok), 1);
        chk("t3_addr_data", sram_addr, 32'h20000000);
        step();
        data_sram_req = 0; sram_addr_ok = 0;
        drain(2);

        // 4: fill to DEPTH, pop blocks push in the same cycle.
        step();
        data_sram_req = 1; sram_addr_ok = 1;
        @(negedge clk);
        chk("t4_fill0", 32'(data_sram_addr_ok), 1);
        for (int i = 1; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("t4_fill", 32'(data_sram_addr_ok), 1);
        end
        step();
        @(negedge clk);
        chk("t4_full_req", 32'(sram_req), 0);
        chk("t4_full_cnt", 32'(outstanding), 4);
        step();
        sram_data_ok = 1;
        @(negedge clk);
        chk("t4_pop_blocks", 32'({sram_req, data_sram_addr_ok, data_sram_data_ok}), 32'b001);
        step();
        sram_data_ok = 0;
        @(negedge clk);
        chk("t4_push_after", 32'(data_sram_addr_ok), 1);
        chk("t4_cnt3", 32'(outstanding), 3);
        step();
        data_sram_req = 0; sram_addr_ok = 0;
        @(negedge clk);
        chk("t4_cnt4", 32'(outstanding), 4);
        drain(4);

        // 5: starvation limit gives D,D,I,D,D,I.
        step();
        inst_sram_req = 1; data_sram_req = 1; sram_addr_ok = 1; sram_data_ok = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("t5_grant", 32'({inst_sram_addr_ok, data_sram_addr_ok}),
                exp5[i] ? 32'b01 : 32'b10);
        end
        step();
        inst_sram_req = 0; data_sram_req = 0; sram_addr_ok = 0;
        drain(1);

        // 6: reset mid-cycle with two outstanding.
        step();
        data_sram_req = 1; sram_addr_ok = 1;
        step();
        step();
        sram_data_ok = 1;
        @(negedge clk);
        chk("t6_pre_cnt", 32'(outstanding), 2);
        step();
        #1 resetn = 0;
        #1;
        chk("t6_rst_outs", 32'({sram_req, data_sram_addr_ok, data_sram_data_ok, inst_sram_data_ok}), 0);
        chk("t6_rst_cnt", 32'(outstanding), 0);
        step();
        clear_inputs();
        resetn = 1;
        sram_data_ok = 1; sram_rdata = 32'h12345678;
        @(negedge clk);
        chk("t6_spurious", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
        chk("t6_cnt", 32'(outstanding), 0);
        step();
        clear_inputs();

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            step();
            resetn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) inst_sram_req = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 3) == 0) data_sram_req = $urandom_range(0, 1) != 0;
            inst_sram_wr    = $urandom_range(0, 1) != 0;
            inst_sram_size  = 2'($urandom_range(0, 3));
            inst_sram_wstrb = 4'($urandom_range(0, 15));
            inst_sram_addr  = $urandom;
            inst_sram_wdata = $urandom;
            data_sram_wr    = $urandom_range(0, 1) != 0;
            data_sram_size  = 2'($urandom_range(0, 3));
            data_sram_wstrb = 4'($urandom_range(0, 15));
            data_sram_addr  = $urandom;
            data_sram_wdata = $urandom;
            sram_addr_ok    = $urandom_range(0, 1) != 0;
            sram_data_ok    = $urandom_range(0, 4) < 2;
            sram_rdata      = $urandom;
        end
        step();
        resetn = 1;
        clear_inputs();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
